// File: rtl/ifm_rd_if.sv
// SDRAM read-master and input-buffer write-port bundle for the input-feature-map loader.
interface ifm_rd_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RAM_ADR_W  = 32,
  parameter int unsigned IFM_ADR_W  = 10,
  parameter int unsigned NUM_BUF    = 8
);
  logic                  sdram_read_n;
  logic [RAM_ADR_W-1:0]  sdram_address;
  logic                  sdram_waitrequest;
  logic [DATA_WIDTH-1:0] sdram_readdata;
  logic                  sdram_readdatavalid;
  logic [NUM_BUF-1:0]    in_buf_write_n;
  logic [IFM_ADR_W-1:0]  in_buf_address;
  logic [DATA_WIDTH-1:0] in_buf_writedata;

  modport master (
    output sdram_read_n, sdram_address, in_buf_write_n, in_buf_address, in_buf_writedata,
    input  sdram_waitrequest, sdram_readdata, sdram_readdatavalid
  );

  modport slave (
    input  sdram_read_n, sdram_address, in_buf_write_n, in_buf_address, in_buf_writedata,
    output sdram_waitrequest, sdram_readdata, sdram_readdatavalid
  );
endinterface

// File: rtl/ifm_rd.sv
// Input-feature-map loader: pipelined Avalon-MM reads of NUM_BUF maps for channel group n,
// scattered in order into the NUM_BUF input buffers.
module ifm_rd #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RAM_ADR_W  = 32,
  parameter int unsigned IFM_ADR_W  = 10,
  parameter int unsigned IFM_SIZE   = 1024,
  parameter int unsigned NUM_BUF    = 8,
  parameter int unsigned N_IDX_SZ   = 8,
  parameter int unsigned IN_BASE    = 0,
  parameter int unsigned MAX_OUTST  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [N_IDX_SZ-1:0] n,
  output logic                done,
  ifm_rd_if.master            bus
);

  localparam int unsigned TOTAL = NUM_BUF * IFM_SIZE;
  localparam int unsigned ISS_W = $clog2(TOTAL + 1);
  localparam int unsigned OST_W = $clog2(MAX_OUTST + 1);
  localparam int unsigned BUF_W = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [RAM_ADR_W-1:0]  base_q, base_d;
  logic [ISS_W-1:0]      iss_q, iss_d;
  logic [OST_W-1:0]      outst_q, outst_d;
  logic [BUF_W-1:0]      b_q, b_d;
  logic [IFM_ADR_W-1:0]  k_q, k_d;
  logic                  read_n_q, read_n_d;
  logic [RAM_ADR_W-1:0]  addr_q, addr_d;
  logic [NUM_BUF-1:0]    wr_n_q, wr_n_d;
  logic [IFM_ADR_W-1:0]  buf_addr_q, buf_addr_d;
  logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
  logic                  done_q, done_d;

  logic acc, rdv, last_rcv;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    iss_d      = iss_q;
    outst_d    = outst_q;
    b_d        = b_q;
    k_d        = k_q;
    addr_d     = addr_q;
    wr_n_d     = '1;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    done_d     = 1'b0;

    // Returns outside an active load are stray and must not disturb the counters.
    acc      = !read_n_q && !bus.sdram_waitrequest;
    rdv      = bus.sdram_readdatavalid && (state_q == S_ISSUE || state_q == S_DRAIN);
    last_rcv = rdv && (b_q == BUF_W'(NUM_BUF - 1)) && (k_q == IFM_ADR_W'(IFM_SIZE - 1));

    if (acc) iss_d = iss_q + ISS_W'(1);
    if (acc && !rdv)      outst_d = outst_q + OST_W'(1);
    else if (!acc && rdv) outst_d = outst_q - OST_W'(1);

    if (rdv) begin
      wr_n_d[b_q] = 1'b0;
      buf_addr_d  = k_q;
      buf_data_d  = bus.sdram_readdata;
      if (k_q == IFM_ADR_W'(IFM_SIZE - 1)) begin
        k_d = '0;
        b_d = b_q + BUF_W'(1);
      end else begin
        k_d = k_q + IFM_ADR_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          base_d  = RAM_ADR_W'(IN_BASE) + RAM_ADR_W'(n) * RAM_ADR_W'(TOTAL);
          iss_d   = '0;
          outst_d = '0;
          b_d     = '0;
          k_d     = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: if (acc && iss_q == ISS_W'(TOTAL - 1)) state_d = S_DRAIN;
      S_DRAIN: if (last_rcv) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Request line is computed from next-cycle counts so a return frees a slot with no bubble.
    done_d   = (state_d == S_DONE);
    read_n_d = !((state_d == S_ISSUE) && (iss_d < ISS_W'(TOTAL)) &&
                 (outst_d < OST_W'(MAX_OUTST)));
    if (state_d == S_ISSUE) addr_d = base_d + RAM_ADR_W'(iss_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      iss_q      <= '0;
      outst_q    <= '0;
      b_q        <= '0;
      k_q        <= '0;
      read_n_q   <= 1'b1;
      addr_q     <= '0;
      wr_n_q     <= '1;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      iss_q      <= iss_d;
      outst_q    <= outst_d;
      b_q        <= b_d;
      k_q        <= k_d;
      read_n_q   <= read_n_d;
      addr_q     <= addr_d;
      wr_n_q     <= wr_n_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      done_q     <= done_d;
    end
  end

  assign done                 = done_q;
  assign bus.sdram_read_n     = read_n_q;
  assign bus.sdram_address    = addr_q;
  assign bus.in_buf_write_n   = wr_n_q;
  assign bus.in_buf_address   = buf_addr_q;
  assign bus.in_buf_writedata = buf_data_q;

endmodule

// File: tb/tb_ifm_rd.sv
// Bench for ifm_rd: SDRAM responder with configurable latency/stalls, buffer-image model
// rebuilt from the strobes, and per-scenario checks against addresses derived from n.
module tb_ifm_rd;
  localparam int unsigned DW = 32, AW = 32, KW = 10, ISZ = 16, NB = 8, NW = 8, MO = 8;
  localparam int unsigned TOT = NB * ISZ;
  localparam logic [AW-1:0] BASE0 = 32'h0000_1000;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, done;
  logic [NW-1:0] n_in = '0;

  ifm_rd_if #(.DATA_WIDTH(DW), .RAM_ADR_W(AW), .IFM_ADR_W(KW), .NUM_BUF(NB)) bus ();

  ifm_rd #(.DATA_WIDTH(DW), .RAM_ADR_W(AW), .IFM_ADR_W(KW), .IFM_SIZE(ISZ), .NUM_BUF(NB),
           .N_IDX_SZ(NW), .IN_BASE(32'h1000), .MAX_OUTST(MO))
    dut (.clk(clk), .rst_n(rst_n), .enable(enable), .n(n_in), .done(done), .bus(bus));

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; int due; } req_t;
  req_t            pend[$];
  logic [AW-1:0]   acc_addr[$];
  logic [DW-1:0]   mem [NB][ISZ];
  bit              rn_log [4096];
  int  cyc, acc_cnt, ret_cnt, wr_cnt, done_cnt, done_cyc, last_wr_cyc, first_acc, last_acc;
  int  first_rdv, max_out, onehot_err, hold_err, order_err, stall_cnt, stall_bad;
  int  lat = 3, wmode = 0;
  bit  inject = 1'b0, prev_stall = 1'b0;
  logic [DW-1:0] salt = '0;
  logic [AW-1:0] prev_addr = '0;
  int  vec = 0, errs = 0;

  // SDRAM responder and output monitor; DUT outputs are stable at the falling edge.
  always @(negedge clk) begin : mon
    logic [NB-1:0] strb;
    int bi;
    req_t r;
    logic w;
    cyc++;
    if (cyc < 4096) rn_log[cyc] = bus.sdram_read_n;
    if (done) begin done_cnt++; done_cyc = cyc; end
    strb = ~bus.in_buf_write_n;
    if (strb != '0) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      if (!$onehot(strb) || bus.in_buf_address >= KW'(ISZ)) onehot_err++;
      else begin
        bi = 0;
        for (int i = 0; i < NB; i++) if (strb[i]) bi = i;
        mem[bi][bus.in_buf_address] = bus.in_buf_writedata;
        if (bi * ISZ + int'(bus.in_buf_address) != wr_cnt - 1) order_err++;
      end
    end
    if (prev_stall && (bus.sdram_read_n !== 1'b0 || bus.sdram_address !== prev_addr)) hold_err++;

    if (!rst_n) pend.delete();
    bus.sdram_readdatavalid = 1'b0;
    bus.sdram_readdata      = $urandom;
    if (inject) bus.sdram_readdatavalid = 1'b1;
    else if (pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      bus.sdram_readdatavalid = 1'b1;
      bus.sdram_readdata      = r.addr ^ salt;
      ret_cnt++;
      if (first_rdv < 0) first_rdv = cyc;
    end
    w = 1'b0;
    if (bus.sdram_read_n == 1'b0) begin
      if (wmode == 1 && acc_cnt == 3 && stall_cnt < 5) begin
        w = 1'b1;
        stall_cnt++;
        if (bus.sdram_address !== 32'h0000_1103) stall_bad++;
      end else if (wmode == 2) w = ($urandom_range(0, 3) == 0);
    end
    bus.sdram_waitrequest = w;
    if (rst_n && bus.sdram_read_n == 1'b0 && !w) begin
      r.addr = bus.sdram_address;
      r.due  = cyc + lat;
      pend.push_back(r);
      acc_addr.push_back(bus.sdram_address);
      acc_cnt++;
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
    end
    if (acc_cnt - ret_cnt > max_out) max_out = acc_cnt - ret_cnt;
    prev_stall = rst_n && (bus.sdram_read_n == 1'b0) && w;
    prev_addr  = bus.sdram_address;
  end

  task automatic clear_model(input int l, input int wm, input logic [DW-1:0] s);
    cyc = 0; acc_cnt = 0; ret_cnt = 0; wr_cnt = 0; done_cnt = 0; done_cyc = -1;
    last_wr_cyc = -2; first_acc = -1; last_acc = -1; first_rdv = -1; max_out = 0;
    onehot_err = 0; hold_err = 0; order_err = 0; stall_cnt = 0; stall_bad = 0;
    lat = l; wmode = wm; salt = s; inject = 1'b0;
    acc_addr.delete();
    for (int b = 0; b < NB; b++) for (int k = 0; k < ISZ; k++) mem[b][k] = 'x;
    for (int c = 0; c < 4096; c++) rn_log[c] = 1'b0;
  endtask

  task automatic start(input logic [NW-1:0] nn, input int l, input int wm, input logic [DW-1:0] s);
    @(posedge clk); #1;
    clear_model(l, wm, s);
    enable = 1'b1; n_in = nn;
    @(posedge clk); #1;
    enable = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 4000 && done_cnt == 0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
  endtask

  function automatic logic [AW-1:0] base_of(input logic [NW-1:0] nn);
    return BASE0 + AW'(nn) * AW'(TOT);
  endfunction

  function automatic int seq_bad(input logic [AW-1:0] base);
    int bad = (acc_addr.size() != TOT) ? 1 : 0;
    for (int i = 0; i < acc_addr.size(); i++) if (acc_addr[i] !== base + AW'(i)) bad++;
    return bad;
  endfunction

  function automatic int mem_bad(input logic [AW-1:0] base);
    int bad = 0;
    for (int b = 0; b < NB; b++)
      for (int k = 0; k < ISZ; k++)
        if (mem[b][k] !== ((base + AW'(b * ISZ + k)) ^ salt)) bad++;
    return bad;
  endfunction

  function automatic int bubbles();
    int bad = 0;
    if (first_acc < 0) return 1;
    for (int c = first_acc; c <= last_acc && c < 4096; c++) if (rn_log[c]) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    vec++; if (bus.sdram_read_n !== 1'b1 || done !== 1'b0) begin errs++;
      $display("FAIL reset_ctl: read_n=%b done=%b want 1/0", bus.sdram_read_n, done); end
    vec++; if (bus.sdram_address !== '0 || bus.in_buf_address !== '0) begin errs++;
      $display("FAIL reset_addr: sdram=%h buf=%h want 0/0", bus.sdram_address, bus.in_buf_address); end
    vec++; if (bus.in_buf_write_n !== '1 || bus.in_buf_writedata !== '0) begin errs++;
      $display("FAIL reset_buf: wr_n=%b data=%h want ff/0", bus.in_buf_write_n, bus.in_buf_writedata); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    start(8'd2, 3, 0, '0);
    wait_done();
    vec++; if (done_cnt !== 1) begin errs++; $display("FAIL basic_done: got %0d want 1", done_cnt); end
    vec++; if (wr_cnt !== TOT) begin errs++; $display("FAIL basic_strobes: got %0d want %0d", wr_cnt, TOT); end
    vec++; if (seq_bad(32'h1100) !== 0) begin errs++; $display("FAIL basic_addr_seq: %0d bad want 0", seq_bad(32'h1100)); end
    vec++; if (mem[0][0] !== 32'h1100) begin errs++; $display("FAIL basic_first: got %h want 1100", mem[0][0]); end
    vec++; if (mem[7][15] !== 32'h117F) begin errs++; $display("FAIL basic_last: got %h want 117f", mem[7][15]); end
    vec++; if (mem_bad(32'h1100) !== 0) begin errs++; $display("FAIL basic_contents: %0d bad want 0", mem_bad(32'h1100)); end
    vec++; if (done_cyc !== last_wr_cyc) begin errs++; $display("FAIL basic_done_align: done@%0d lastwr@%0d", done_cyc, last_wr_cyc); end
    vec++; if (onehot_err + order_err !== 0) begin errs++; $display("FAIL basic_strobe_shape: onehot=%0d order=%0d want 0", onehot_err, order_err); end
    vec++; if (bubbles() !== 0) begin errs++; $display("FAIL basic_throughput: %0d bubbles want 0", bubbles()); end
  endtask

  task automatic test_waitreq();
    start(8'd2, 3, 1, '0);
    wait_done();
    vec++; if (stall_cnt !== 5 || stall_bad !== 0) begin errs++;
      $display("FAIL wait_stall: cycles=%0d badaddr=%0d want 5/0", stall_cnt, stall_bad); end
    vec++; if (hold_err !== 0) begin errs++; $display("FAIL wait_hold: %0d changes want 0", hold_err); end
    vec++; if (seq_bad(32'h1100) !== 0) begin errs++; $display("FAIL wait_addr_seq: %0d bad want 0", seq_bad(32'h1100)); end
    vec++; if (mem_bad(32'h1100) !== 0 || done_cnt !== 1) begin errs++;
      $display("FAIL wait_contents: bad=%0d done=%0d want 0/1", mem_bad(32'h1100), done_cnt); end
  endtask

  task automatic test_outst_limit();
    start(8'd2, 20, 0, '0);
    wait_done();
    vec++; if (max_out !== MO) begin errs++; $display("FAIL limit_max: got %0d want %0d", max_out, MO); end
    vec++; if (first_rdv !== first_acc + 20) begin errs++;
      $display("FAIL limit_latency: rdv@%0d want %0d", first_rdv, first_acc + 20); end
    vec++; if (rn_log[first_acc + 8] !== 1'b1 || rn_log[first_rdv] !== 1'b1) begin errs++;
      $display("FAIL limit_pause: read_n after8=%b at_rdv=%b want 1/1", rn_log[first_acc + 8], rn_log[first_rdv]); end
    vec++; if (rn_log[first_rdv + 1] !== 1'b0) begin errs++;
      $display("FAIL limit_resume: read_n=%b want 0", rn_log[first_rdv + 1]); end
    vec++; if (mem_bad(32'h1100) !== 0 || done_cnt !== 1) begin errs++;
      $display("FAIL limit_contents: bad=%0d done=%0d want 0/1", mem_bad(32'h1100), done_cnt); end
  endtask

  task automatic test_same_cycle();
    start(8'd3, 7, 0, 32'h5A5A_0000);
    wait_done();
    vec++; if (max_out !== MO - 1) begin errs++; $display("FAIL same_max: got %0d want %0d", max_out, MO - 1); end
    vec++; if (bubbles() !== 0) begin errs++; $display("FAIL same_bubbles: got %0d want 0", bubbles()); end
    vec++; if (mem_bad(base_of(8'd3)) !== 0) begin errs++; $display("FAIL same_contents: %0d bad want 0", mem_bad(base_of(8'd3))); end
  endtask

  task automatic test_enable_ignored();
    @(posedge clk); #1;
    clear_model(3, 0, '0);
    inject = 1'b1;
    repeat (3) @(posedge clk); #1;
    inject = 1'b0;
    repeat (3) @(posedge clk);
    vec++; if (wr_cnt !== 0) begin errs++; $display("FAIL idle_rdv: %0d writes want 0", wr_cnt); end
    start(8'd1, 4, 0, '0);
    repeat (10) @(posedge clk); #1;
    enable = 1'b1; n_in = 8'd5;
    @(posedge clk); #1 enable = 1'b0;
    wait_done();
    repeat (30) @(posedge clk);
    vec++; if (done_cnt !== 1 || acc_cnt !== TOT) begin errs++;
      $display("FAIL en_restart: done=%0d reqs=%0d want 1/%0d", done_cnt, acc_cnt, TOT); end
    vec++; if (seq_bad(base_of(8'd1)) !== 0) begin errs++; $display("FAIL en_addr_seq: %0d bad want 0", seq_bad(base_of(8'd1))); end
    vec++; if (mem_bad(base_of(8'd1)) !== 0 || order_err !== 0) begin errs++;
      $display("FAIL en_contents: bad=%0d order=%0d want 0/0", mem_bad(base_of(8'd1)), order_err); end
  endtask

  task automatic test_reset_mid();
    start(8'd2, 4, 0, '0);
    for (int i = 0; i < 2000 && wr_cnt < 50; i++) @(posedge clk);
    vec++; if (wr_cnt < 50) begin errs++; $display("FAIL mid_reach50: got %0d want 50", wr_cnt); end
    #2 rst_n = 1'b0;
    #1;
    vec++; if (bus.sdram_read_n !== 1'b1 || bus.in_buf_write_n !== '1 || done !== 1'b0) begin errs++;
      $display("FAIL mid_reset_ctl: read_n=%b wr_n=%b done=%b want 1/ff/0", bus.sdram_read_n, bus.in_buf_write_n, done); end
    vec++; if (bus.sdram_address !== '0 || bus.in_buf_address !== '0 || bus.in_buf_writedata !== '0) begin errs++;
      $display("FAIL mid_reset_data: addr=%h baddr=%h data=%h want 0", bus.sdram_address, bus.in_buf_address, bus.in_buf_writedata); end
    repeat (3) @(posedge clk); #1 rst_n = 1'b1;
    start(8'd0, 3, 0, '0);
    wait_done();
    vec++; if (seq_bad(32'h1000) !== 0) begin errs++; $display("FAIL mid_rerun_seq: %0d bad want 0", seq_bad(32'h1000)); end
    vec++; if (mem_bad(32'h1000) !== 0 || done_cnt !== 1 || wr_cnt !== TOT) begin errs++;
      $display("FAIL mid_rerun: bad=%0d done=%0d writes=%0d want 0/1/%0d", mem_bad(32'h1000), done_cnt, wr_cnt, TOT); end
  endtask

  task automatic test_random();
    logic [NW-1:0] nn;
    for (int it = 0; it < 4; it++) begin
      nn = NW'($urandom_range(0, 255));
      start(nn, $urandom_range(1, 12), 2, $urandom);
      wait_done();
      vec++; if (done_cnt !== 1 || acc_cnt !== TOT) begin errs++;
        $display("FAIL rand%0d_done: done=%0d reqs=%0d want 1/%0d", it, done_cnt, acc_cnt, TOT); end
      vec++; if (seq_bad(base_of(nn)) !== 0) begin errs++; $display("FAIL rand%0d_seq: %0d bad want 0", it, seq_bad(base_of(nn))); end
      vec++; if (mem_bad(base_of(nn)) !== 0) begin errs++; $display("FAIL rand%0d_contents: %0d bad want 0", it, mem_bad(base_of(nn))); end
      vec++; if (max_out > MO || hold_err !== 0 || order_err !== 0 || done_cyc !== last_wr_cyc) begin errs++;
        $display("FAIL rand%0d_rules: maxout=%0d hold=%0d order=%0d done@%0d lastwr@%0d", it, max_out, hold_err, order_err, done_cyc, last_wr_cyc); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_waitreq();
    test_outst_limit();
    test_same_cycle();
    test_enable_ignored();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
